// File: rtl/rocc_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : rocc_dispatch
//  Purpose  : In-order dispatch buffer between the issue stage and a RoCC
//             accelerator. Instructions are queued in a circular buffer, sent
//             in order on the cmd interface, and retired from the head when
//             complete. Each live retire produces a registered writeback.
//             Flushes kill in-flight work, but responses the accelerator
//             still owes are consumed without producing a writeback.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_ni         clock, asynchronous active-low reset
//    issue_*               instruction + operands + trans_id from issue stage
//    flush_i               kill every unretired instruction
//    cmd_*                 command channel to the accelerator (valid/ready)
//    resp_*                response channel from the accelerator (valid/ready)
//    wb_*                  registered writeback pulse to the scoreboard
//    busy_o                at least one entry in flight
// ============================================================================
module rocc_dispatch #(
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3,
  parameter int XLEN          = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_insn_i,
  input  logic [XLEN-1:0]          issue_rs1_i,
  input  logic [XLEN-1:0]          issue_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic                     flush_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [31:0]              cmd_insn_o,
  output logic [XLEN-1:0]          cmd_rs1_o,
  output logic [XLEN-1:0]          cmd_rs2_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [XLEN-1:0]          resp_data_i,
  input  logic [4:0]               resp_rd_i,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_error_o,
  output logic                     busy_o
);

  localparam int                 c_idx_w   = $clog2(DEPTH);
  localparam int                 c_ptr_w   = c_idx_w + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0] c_full    = c_ptr_w'(DEPTH);

  // Entry storage
  logic [31:0]              r_insn [DEPTH];
  logic [XLEN-1:0]          r_rs1  [DEPTH];
  logic [XLEN-1:0]          r_rs2  [DEPTH];
  logic [TRANS_ID_BITS-1:0] r_tid  [DEPTH];
  logic [DEPTH-1:0]         r_killed;

  // Pointers carry a wrap bit so full and empty are distinguishable
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_send;
  logic [c_ptr_w-1:0] r_tail;

  logic [c_idx_w-1:0] w_head_idx;
  logic [c_idx_w-1:0] w_send_idx;
  logic [c_idx_w-1:0] w_tail_idx;
  logic [c_ptr_w-1:0] w_count;
  logic [c_ptr_w-1:0] w_send_nxt;
  logic               w_issue_hs;
  logic               w_cmd_hs;
  logic               w_head_sent;
  logic               w_head_xd;
  logic               w_retire;
  logic               w_wb_fire;

  assign w_head_idx = r_head[c_idx_w-1:0];
  assign w_send_idx = r_send[c_idx_w-1:0];
  assign w_tail_idx = r_tail[c_idx_w-1:0];
  assign w_count    = r_tail - r_head;

  // Issue side: no allocation while flushing, and no same-cycle reuse of a
  // slot being freed (count is taken from registered pointers only).
  assign issue_ready_o = (w_count != c_full) && !flush_i;
  assign w_issue_hs    = issue_valid_i && issue_ready_o;

  // Command side is a direct read of the entry at the send pointer.
  assign cmd_valid_o = (r_send != r_tail);
  assign cmd_insn_o  = r_insn[w_send_idx];
  assign cmd_rs1_o   = r_rs1[w_send_idx];
  assign cmd_rs2_o   = r_rs2[w_send_idx];
  assign w_cmd_hs    = cmd_valid_o && cmd_ready_i;
  assign w_send_nxt  = w_cmd_hs ? (r_send + c_ptr_one) : r_send;

  // Retire: only the head, only once it has been sent. xd=1 entries wait for
  // their response; any response arriving in another state is held off.
  assign w_head_sent  = (r_head != r_send);
  assign w_head_xd    = r_insn[w_head_idx][14];
  assign resp_ready_o = w_head_sent && w_head_xd;
  assign w_retire     = w_head_sent && (!w_head_xd || resp_valid_i);
  // A retire during a flush cycle belongs to killed work too.
  assign w_wb_fire    = w_retire && !r_killed[w_head_idx] && !flush_i;

  assign busy_o = (r_head != r_tail);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head   <= '0;
      r_send   <= '0;
      r_tail   <= '0;
      r_killed <= '0;
    end else begin
      if (w_retire) begin
        r_head <= r_head + c_ptr_one;
      end
      r_send <= w_send_nxt;
      if (flush_i) begin
        // Unsent entries are dropped by pulling tail back to send. Marking
        // every slot killed is safe: free slots are cleared on allocation.
        r_tail   <= w_send_nxt;
        r_killed <= '1;
      end else if (w_issue_hs) begin
        r_tail               <= r_tail + c_ptr_one;
        r_killed[w_tail_idx] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_issue_hs) begin
      r_insn[w_tail_idx] <= issue_insn_i;
      r_rs1[w_tail_idx]  <= issue_rs1_i;
      r_rs2[w_tail_idx]  <= issue_rs2_i;
      r_tid[w_tail_idx]  <= issue_trans_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_result_o   <= '0;
      wb_trans_id_o <= '0;
      wb_error_o    <= 1'b0;
    end else begin
      wb_valid_o <= w_wb_fire;
      if (w_wb_fire) begin
        wb_trans_id_o <= r_tid[w_head_idx];
        wb_result_o   <= w_head_xd ? resp_data_i : '0;
        wb_error_o    <= w_head_xd && (resp_rd_i != r_insn[w_head_idx][11:7]);
      end
    end
  end

endmodule
`default_nettype wire
